usb_slfifo_wr_ctrl: RTL and testbench
=====================================

// Module: usb_slfifo_wr_ctrl
// PURPOSE
//  Write-side sequencer for the CY7C68013A Slave FIFO (synchronous mode, IFCLK driven by FPGA).
//  Accepts a 16-bit word stream (valid/ready) from on-chip sources and drives FD[15:0] (PD:PB), SLWR, FIFOADR, PKTEND, SLOE.
//  Throttles on FLAGB and commits full packets automatically. Short packets end with PKTEND on flush, idle timeout or disable.
// PARAMETERS
//  EP_ADDR       2'b10  FIFOADR[1:0] value driven constantly (EP6 IN)
//  PKT_WORDS     256    words per full packet (512-byte bulk), >=2
//  IDLE_TIMEOUT  1024   idle cycles with a partial packet before forced PKTEND, >=4
//  CNT_W         32     width of words_sent
// PORTS
//  USB_IFCLK     in   1   interface clock, all logic on rising edge
//  USB_RESET2    in   1   asynchronous active-low reset
//  enable        in   1   1 = stream; 0 = close partial packet, go idle
//  s_data        in   16  source word, FD[15:8]=PD, FD[7:0]=PB
//  s_valid       in   1   source word available
//  s_ready       out  1   word accepted when s_valid&s_ready at clock edge
//  flush         in   1   1-cycle pulse: commit current partial packet
//  usb_full_n    in   1   FLAGB, almost-full (firmware sets >=2 slots margin), low = stop
//  usb_fd        out  16  FIFO data bus
//  usb_fd_oe     out  1   FD output enable
//  usb_slwr_n    out  1   SLWR, active low, one cycle per word
//  usb_pktend_n  out  1   PKTEND, active low, one-cycle pulse
//  usb_sloe_n    out  1   SLOE, tied 1 (FPGA always drives FD)
//  usb_fifoadr   out  2   = EP_ADDR
//  busy          out  1   state != IDLE
//  words_sent    out  CNT_W  total SLWR strobes, wraps
//  pkt_count     out  16  committed packets (auto + PKTEND), wraps
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE. Outputs: slwr_n=1, pktend_n=1, sloe_n=1, fd=0, fd_oe=0, s_ready=0, busy=0.
//   Counters, pkt_cnt, timeout counter and flush_pend are cleared. fifoadr=EP_ADDR.
//   A reset mid-packet abandons it; FX2 buffer cleanup is done by firmware.
//  All outputs are registered. usb_full_n is registered once (full_q) before use.
//  States: IDLE, STREAM, END_GAP, PKTEND, POST.
//   IDLE: fd_oe=0. If enable=1, go to STREAM next cycle with fd_oe=1.
//   STREAM: s_ready = enable & full_q & ~flush_pend & ~end_req.
//    Transfer at edge N: fd<=s_data, slwr_n<=0 for cycle N+1 only.
//    Same edge: words_sent++ and pkt_cnt++.
//    Consecutive cycles can each write one word (full throughput).
//    Packet wrap: when pkt_cnt reaches PKT_WORDS it resets to 0 and pkt_count++. No PKTEND (FX2 AUTOIN commits).
//    full_q=0: no new accepts. At most 2 SLWR are issued after FLAGB falls. Resume the cycle after full_q=1.
//    Timeout counter: increments each STREAM cycle with no transfer and pkt_cnt!=0. Cleared on transfer.
//   End request (end_req) is raised by any of: flush_pend; timeout counter = IDLE_TIMEOUT-1; enable=0.
//    On end_req: if pkt_cnt!=0, go to END_GAP. If pkt_cnt==0, clear flush_pend (no ZLP) and go to IDLE if enable=0, else stay in STREAM.
//   END_GAP: one cycle, slwr_n=1. Gives >=1 cycle between the last SLWR and PKTEND.
//   PKTEND: pktend_n=0 for exactly 1 cycle, issued regardless of FLAGB. pkt_cnt<=0, pkt_count++, flush_pend<=0.
//   POST: one cycle. Then go to STREAM if enable=1, else IDLE.
//  flush: captured into flush_pend in any state except reset. Held until serviced.
//   Flush in the same cycle as a transfer: that word is written first and is part of the committed packet.
//   Flush coinciding with a natural wrap (pkt_cnt->0): it is discarded, no PKTEND.
//  slwr_n and pktend_n are never low in the same cycle.
//  s_ready is never 1 outside STREAM.
// TESTING
//  T1 PKT_WORDS=4, full_n=1, 8 words 0x0001..0x0008 back-to-back
//   -> 8 consecutive SLWR cycles, fd in order, pkt_count=2, pktend_n stays 1.
//  T2 IDLE_TIMEOUT=16, 3 words then s_valid=0
//   -> single pktend_n pulse 18 cycles after last SLWR cycle; pkt_count=1, words_sent=3.
//  T3 full_n driven low mid-stream for 10 cycles
//   -> s_ready low within 2 cycles; <=2 SLWR after fall; resumes; sequence 0..31 intact, no dup/loss.
//  T4 flush pulsed on edge accepting 2nd word of partial
//   -> SLWR word2, END_GAP, PKTEND. A later flush with pkt_cnt=0 -> no PKTEND.
//  T5 PKT_WORDS=8, 5 words written, enable dropped
//   -> PKTEND pulse, then IDLE; busy=0, fd_oe=0, pkt_count=1.
//  T6 USB_RESET2 low mid-stream (slwr_n=0)
//   -> same-cycle slwr_n=1, fd_oe=0, counters 0. After release with enable=1, streaming restarts from pkt_cnt=0.

Source files
------------

// File: rtl/usb_slfifo_wr_ctrl.sv
// rtl/usb_slfifo_wr_ctrl.sv - CY7C68013A slave FIFO write sequencer
// Streams 16-bit words into the FX2 IN endpoint, closing short packets with PKTEND.
module usb_slfifo_wr_ctrl #(
  parameter logic [1:0] EP_ADDR      = 2'b10,
  parameter int         PKT_WORDS    = 256,
  parameter int         IDLE_TIMEOUT = 1024,
  parameter int         CNT_W        = 32
) (
  input  logic             USB_IFCLK,
  input  logic             USB_RESET2,
  input  logic             enable,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             flush,
  input  logic             usb_full_n,
  output logic [15:0]      usb_fd,
  output logic             usb_fd_oe,
  output logic             usb_slwr_n,
  output logic             usb_pktend_n,
  output logic             usb_sloe_n,
  output logic [1:0]       usb_fifoadr,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent,
  output logic [15:0]      pkt_count
);

  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_END_GAP,
    S_PKTEND,
    S_POST
  } state_e;

  state_e           state_q, state_d;
  logic             full_q;
  logic [15:0]      fd_q, fd_d;
  logic             slwr_n_q, slwr_n_d;
  logic             pktend_n_q, pktend_n_d;
  logic             busy_q;
  logic [CNT_W-1:0] words_q, words_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             flush_pend_q, flush_pend_d;

  logic end_req;
  logic xfer;
  logic pkt_last;

  assign end_req  = flush_pend_q | (tmo_q == TW'(IDLE_TIMEOUT - 1)) | ~enable;
  assign pkt_last = (pkt_cnt_q == PW'(PKT_WORDS - 1));
  // Handshake follows this cycle's enable so a source never pushes into a closing packet.
  assign s_ready  = (state_q == S_STREAM) & full_q & ~end_req;
  assign xfer     = s_ready & s_valid;

  always_comb begin
    state_d      = state_q;
    fd_d         = fd_q;
    slwr_n_d     = 1'b1;
    pktend_n_d   = 1'b1;
    words_d      = words_q;
    pkt_count_d  = pkt_count_q;
    pkt_cnt_d    = pkt_cnt_q;
    tmo_d        = '0;
    flush_pend_d = flush_pend_q | flush;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (xfer) begin
          fd_d     = s_data;
          slwr_n_d = 1'b0;
          words_d  = words_q + CNT_W'(1);
          if (pkt_last) begin
            // AUTOIN commits the full packet; a flush landing on the wrap has nothing left to close.
            pkt_cnt_d    = '0;
            pkt_count_d  = pkt_count_q + 16'd1;
            flush_pend_d = 1'b0;
          end else begin
            pkt_cnt_d = pkt_cnt_q + PW'(1);
          end
        end else if (end_req) begin
          if (pkt_cnt_q != '0) begin
            state_d = S_END_GAP;
          end else begin
            flush_pend_d = 1'b0;
            if (!enable) state_d = S_IDLE;
          end
        end else if (pkt_cnt_q != '0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_END_GAP: begin
        state_d = S_PKTEND;
      end
      S_PKTEND: begin
        pktend_n_d   = 1'b0;
        pkt_cnt_d    = '0;
        pkt_count_d  = pkt_count_q + 16'd1;
        flush_pend_d = 1'b0;
        state_d      = S_POST;
      end
      S_POST: begin
        state_d = enable ? S_STREAM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge USB_IFCLK or negedge USB_RESET2) begin
    if (!USB_RESET2) begin
      state_q      <= S_IDLE;
      full_q       <= 1'b0;
      fd_q         <= '0;
      slwr_n_q     <= 1'b1;
      pktend_n_q   <= 1'b1;
      busy_q       <= 1'b0;
      words_q      <= '0;
      pkt_count_q  <= '0;
      pkt_cnt_q    <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= usb_full_n;
      fd_q         <= fd_d;
      slwr_n_q     <= slwr_n_d;
      pktend_n_q   <= pktend_n_d;
      busy_q       <= (state_d != S_IDLE);
      words_q      <= words_d;
      pkt_count_q  <= pkt_count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      tmo_q        <= tmo_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign usb_fd       = fd_q;
  assign usb_fd_oe    = busy_q;
  assign usb_slwr_n   = slwr_n_q;
  assign usb_pktend_n = pktend_n_q;
  assign usb_sloe_n   = 1'b1;
  assign usb_fifoadr  = EP_ADDR;
  assign busy         = busy_q;
  assign words_sent   = words_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_usb_slfifo_wr_ctrl.sv
// tb/tb_usb_slfifo_wr_ctrl.sv - randomized bench for the slave FIFO write sequencer
module tb_usb_slfifo_wr_ctrl;
  localparam int PKT_WORDS    = 4;
  localparam int IDLE_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        flush = 1'b0;
  logic        usb_full_n = 1'b1;
  logic        s_ready, usb_fd_oe, usb_slwr_n, usb_pktend_n, usb_sloe_n, busy;
  logic [15:0] usb_fd, pkt_count;
  logic [1:0]  usb_fifoadr;
  logic [31:0] words_sent;

  usb_slfifo_wr_ctrl #(
    .EP_ADDR(2'b10), .PKT_WORDS(PKT_WORDS), .IDLE_TIMEOUT(IDLE_TIMEOUT), .CNT_W(32)
  ) dut (
    .USB_IFCLK(clk), .USB_RESET2(rst_n), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .flush(flush), .usb_full_n(usb_full_n),
    .usb_fd(usb_fd), .usb_fd_oe(usb_fd_oe), .usb_slwr_n(usb_slwr_n),
    .usb_pktend_n(usb_pktend_n), .usb_sloe_n(usb_sloe_n), .usb_fifoadr(usb_fifoadr),
    .busy(busy), .words_sent(words_sent), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tout_cnt = 0;

  // Reference model: every accepted word must appear on the bus the next cycle; packets close
  // either after PKT_WORDS words or by a PKTEND on a non-empty packet.
  int          cyc = 0;
  int          n_slwr, n_pktend, n_acc, m_words, m_pkts, m_in_pkt;
  int          run_cur, run_max, last_slwr_cyc, last_pktend_cyc;
  bit          acc_pend;
  logic [15:0] acc_word;
  logic        prev_full_n;

  always @(negedge clk) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      n_slwr = 0; n_pktend = 0; n_acc = 0; m_words = 0; m_pkts = 0; m_in_pkt = 0;
      run_cur = 0; acc_pend = 1'b0; prev_full_n = 1'b1;
    end else begin
      vectors++;
      if (acc_pend && (usb_slwr_n !== 1'b0 || usb_fd !== acc_word)) begin
        miscompares++;
        $display("FAIL slwr_data cyc=%0d: slwr_n=%b fd=%h, required slwr_n=0 fd=%h", cyc, usb_slwr_n, usb_fd, acc_word);
      end else if (!acc_pend && usb_slwr_n !== 1'b1) begin
        miscompares++;
        $display("FAIL spurious_slwr cyc=%0d: slwr_n=%b, required 1", cyc, usb_slwr_n);
      end
      vectors++;
      if (usb_slwr_n === 1'b0 && usb_pktend_n === 1'b0) begin
        miscompares++;
        $display("FAIL slwr_pktend_overlap cyc=%0d: both low, required at most one", cyc);
      end
      if (usb_slwr_n === 1'b0) begin
        n_slwr++; m_words++; m_in_pkt++; last_slwr_cyc = cyc; run_cur++;
        if (run_cur > run_max) run_max = run_cur;
        if (m_in_pkt == PKT_WORDS) begin m_in_pkt = 0; m_pkts++; end
      end else begin
        run_cur = 0;
      end
      if (usb_pktend_n === 1'b0) begin
        n_pktend++; last_pktend_cyc = cyc;
        vectors++;
        if (m_in_pkt == 0) begin
          miscompares++;
          $display("FAIL pktend_empty cyc=%0d: words in packet=%0d, required nonzero", cyc, m_in_pkt);
        end
        m_in_pkt = 0; m_pkts++;
      end
      vectors++;
      if (words_sent !== 32'(m_words) || pkt_count !== 16'(m_pkts)) begin
        miscompares++;
        $display("FAIL counters cyc=%0d: words_sent=%0d pkt_count=%0d, required %0d %0d", cyc, words_sent, pkt_count, m_words, m_pkts);
      end
      vectors++;
      if (s_ready === 1'b1 && (busy !== 1'b1 || usb_fd_oe !== 1'b1 || prev_full_n === 1'b0)) begin
        miscompares++;
        $display("FAIL s_ready_gate cyc=%0d: s_ready=1 busy=%b fd_oe=%b prev_full_n=%b, required s_ready=0", cyc, busy, usb_fd_oe, prev_full_n);
      end
      vectors++;
      if (usb_sloe_n !== 1'b1 || usb_fifoadr !== 2'b10) begin
        miscompares++;
        $display("FAIL static_pins cyc=%0d: sloe_n=%b fifoadr=%b, required 1 10", cyc, usb_sloe_n, usb_fifoadr);
      end
      acc_pend = (s_valid === 1'b1 && s_ready === 1'b1);
      acc_word = s_data;
      if (acc_pend) n_acc++;
      prev_full_n = usb_full_n;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; s_valid = 1'b0; flush = 1'b0; usb_full_n = 1'b1; s_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1);
  endtask

  task automatic send_word(input logic [15:0] d, input bit flush_on_acc);
    bit done;
    done = 1'b0;
    s_data = d; s_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        if (flush_on_acc) flush = 1'b1;
        done = 1'b1;
      end
    end
    step(1);
    s_valid = 1'b0; flush = 1'b0;
    if (!done) tout_cnt++;
  endtask

  task automatic send_gap(input logic [15:0] d, input int max_gap);
    step(int'($urandom_range(max_gap, 0)));
    send_word(d, 1'b0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({usb_slwr_n, usb_pktend_n, usb_sloe_n, usb_fd_oe, s_ready, busy} !== 6'b111000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {slwr,pktend,sloe,oe,rdy,busy}=%b, required 111000", {usb_slwr_n, usb_pktend_n, usb_sloe_n, usb_fd_oe, s_ready, busy});
    end
    vectors++;
    if (usb_fd !== 16'h0 || usb_fifoadr !== 2'b10 || words_sent !== 32'd0 || pkt_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_data: fd=%h adr=%b words=%0d pkts=%0d, required 0 10 0 0", usb_fd, usb_fifoadr, words_sent, pkt_count);
    end
    do_reset();
    step(3);
    vectors++;
    if (busy !== 1'b0 || usb_fd_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: busy=%b fd_oe=%b, required 0 0", busy, usb_fd_oe);
    end
    enable = 1'b1;
    step(1);
    vectors++;
    if (busy !== 1'b1 || usb_fd_oe !== 1'b1 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_to_stream: busy=%b fd_oe=%b s_ready=%b, required 1 1 1", busy, usb_fd_oe, s_ready);
    end
    enable = 1'b0;
    step(2);
    vectors++;
    if (busy !== 1'b0 || n_pktend != 0) begin
      miscompares++;
      $display("FAIL empty_disable: busy=%b pktends=%0d, required 0 0", busy, n_pktend);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    run_max = 0;
    for (int w = 1; w <= 8; w++) send_word(16'(w), 1'b0);
    step(3);
    vectors++;
    if (n_slwr != 8 || run_max != 8 || tout_cnt != 0) begin
      miscompares++;
      $display("FAIL b2b_run: slwr=%0d run=%0d stalls=%0d, required 8 8 0", n_slwr, run_max, tout_cnt);
    end
    vectors++;
    if (pkt_count !== 16'd2 || words_sent !== 32'd8 || n_pktend != 0) begin
      miscompares++;
      $display("FAIL b2b_pkts: pkt_count=%0d words=%0d pktends=%0d, required 2 8 0", pkt_count, words_sent, n_pktend);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1'b1;
    for (int w = 0; w < 3; w++) send_gap(16'($urandom), 2);
    for (int i = 0; i < 40 && n_pktend == 0; i++) step(1);
    step(4);
    vectors++;
    if (n_pktend != 1 || last_pktend_cyc - last_slwr_cyc != 18) begin
      miscompares++;
      $display("FAIL timeout_pktend: pulses=%0d delay=%0d, required 1 18", n_pktend, last_pktend_cyc - last_slwr_cyc);
    end
    vectors++;
    if (pkt_count !== 16'd1 || words_sent !== 32'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_counts: pkt_count=%0d words=%0d busy=%b, required 1 3 1", pkt_count, words_sent, busy);
    end
  endtask

  task automatic test_full_throttle();
    int s0, s1;
    do_reset();
    enable = 1'b1;
    fork
      begin
        for (int w = 0; w < 32; w++) send_gap(16'(w), 1);
      end
      begin
        step(int'($urandom_range(14, 6)));
        usb_full_n = 1'b0;
        s0 = n_slwr;
        step(10);
        s1 = n_slwr;
        usb_full_n = 1'b1;
      end
    join
    step(3);
    vectors++;
    if (s1 - s0 > 2) begin
      miscompares++;
      $display("FAIL full_overrun: slwr while full=%0d, required <=2", s1 - s0);
    end
    vectors++;
    if (words_sent !== 32'd32 || pkt_count !== 16'd8 || tout_cnt != 0) begin
      miscompares++;
      $display("FAIL full_resume: words=%0d pkt_count=%0d stalls=%0d, required 32 8 0", words_sent, pkt_count, tout_cnt);
    end
  endtask

  task automatic test_flush();
    int d;
    do_reset();
    enable = 1'b1;
    send_word(16'($urandom), 1'b0);
    send_word(16'($urandom), 1'b1);
    for (int i = 0; i < 10 && n_pktend == 0; i++) step(1);
    step(3);
    d = last_pktend_cyc - last_slwr_cyc;
    vectors++;
    if (n_pktend != 1 || d < 2 || d > 3) begin
      miscompares++;
      $display("FAIL flush_pktend: pulses=%0d gap=%0d, required 1 and 2..3", n_pktend, d);
    end
    vectors++;
    if (pkt_count !== 16'd1 || words_sent !== 32'd2) begin
      miscompares++;
      $display("FAIL flush_counts: pkt_count=%0d words=%0d, required 1 2", pkt_count, words_sent);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(8);
    send_word(16'($urandom), 1'b0);
    step(6);
    vectors++;
    if (n_pktend != 1 || pkt_count !== 16'd1) begin
      miscompares++;
      $display("FAIL flush_empty: pulses=%0d pkt_count=%0d, required 1 1", n_pktend, pkt_count);
    end
    send_word(16'($urandom), 1'b0);
    send_word(16'($urandom), 1'b0);
    send_word(16'($urandom), 1'b1);
    step(8);
    vectors++;
    if (n_pktend != 1 || pkt_count !== 16'd2 || words_sent !== 32'd6) begin
      miscompares++;
      $display("FAIL flush_on_wrap: pulses=%0d pkt_count=%0d words=%0d, required 1 2 6", n_pktend, pkt_count, words_sent);
    end
  endtask

  task automatic test_disable();
    do_reset();
    enable = 1'b1;
    for (int w = 0; w < 3; w++) send_gap(16'($urandom), 1);
    step(1);
    enable = 1'b0;
    for (int i = 0; i < 15 && busy !== 1'b0; i++) step(1);
    step(2);
    vectors++;
    if (n_pktend != 1 || pkt_count !== 16'd1 || words_sent !== 32'd3) begin
      miscompares++;
      $display("FAIL disable_commit: pulses=%0d pkt_count=%0d words=%0d, required 1 1 3", n_pktend, pkt_count, words_sent);
    end
    vectors++;
    if ({busy, usb_fd_oe, s_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL disable_idle: {busy,oe,rdy}=%b, required 000", {busy, usb_fd_oe, s_ready});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    vectors++;
    if (usb_slwr_n !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_slwr: slwr_n=%b, required 0", usb_slwr_n);
    end
    s_data = 16'h3333; s_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({usb_slwr_n, usb_fd_oe, busy, s_ready} !== 4'b1000 || words_sent !== 32'd0 || pkt_count !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset: {slwr,oe,busy,rdy}=%b words=%0d pkts=%0d, required 1000 0 0", {usb_slwr_n, usb_fd_oe, busy, s_ready}, words_sent, pkt_count);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    s_valid = 1'b0;
    step(1);
    for (int w = 0; w < 4; w++) send_word(16'($urandom), 1'b0);
    step(3);
    vectors++;
    if (pkt_count !== 16'd1 || words_sent !== 32'd4 || n_pktend != 0) begin
      miscompares++;
      $display("FAIL restart_from_zero: pkt_count=%0d words=%0d pktends=%0d, required 1 4 0", pkt_count, words_sent, n_pktend);
    end
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      s_valid    = ($urandom_range(3, 0) != 0);
      s_data     = 16'($urandom);
      usb_full_n = ($urandom_range(9, 0) != 0);
      flush      = ($urandom_range(39, 0) == 0);
      enable     = ($urandom_range(99, 0) != 0);
      step(1);
    end
    s_valid = 1'b0; flush = 1'b0; usb_full_n = 1'b1; enable = 1'b0;
    for (int i = 0; i < 30 && busy !== 1'b0; i++) step(1);
    step(2);
    vectors++;
    if (busy !== 1'b0 || words_sent !== 32'(n_acc) || m_in_pkt != 0) begin
      miscompares++;
      $display("FAIL random_drain: busy=%b words=%0d accepted=%0d open_words=%0d, required 0 equal 0", busy, words_sent, n_acc, m_in_pkt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_full_throttle();
    test_flush();
    test_disable();
    test_reset_mid();
    test_random();
    vectors++;
    if (tout_cnt != 0) begin
      miscompares++;
      $display("FAIL handshake_stall: stalled sends=%0d, required 0", tout_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
